// File: rtl/timekeeper_core.sv
// Time-of-day counter: prescaled h/m/s with BCD load, 12h/24h display
// and registered rollover tick pulses.
module timekeeper_core #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       load_en,
  input  logic       mode_12h,
  input  logic [1:0] i_hours_left,
  input  logic [3:0] i_hours_right,
  input  logic [2:0] i_minutes_left,
  input  logic [3:0] i_minutes_right,
  input  logic [2:0] i_seconds_left,
  input  logic [3:0] i_seconds_right,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [4:0] o_hours_disp,
  output logic       o_pm,
  output logic       o_sec_tick,
  output logic       o_min_tick,
  output logic       o_hour_tick,
  output logic       o_day_tick,
  output logic       o_load_err
);

  localparam int PS_W =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_MAX =
    PS_W'(TICKS_PER_SEC - 1);

  logic [PS_W-1:0] ps;
  logic [5:0]      ld_h;
  logic [5:0]      ld_m;
  logic [5:0]      ld_s;
  logic            ld_ok;
  logic            adv;
  logic            s_wrap;
  logic            m_wrap;
  logic            h_wrap;

  // ld_m/ld_s may overflow for bad digits; ld_ok rejects those first
  always_comb begin
    ld_h = 6'(i_hours_left) * 6'd10 + 6'(i_hours_right);
    ld_m = 6'(i_minutes_left) * 6'd10 + 6'(i_minutes_right);
    ld_s = 6'(i_seconds_left) * 6'd10 + 6'(i_seconds_right);
    ld_ok = (i_hours_right <= 4'd9) &&
            (i_minutes_right <= 4'd9) &&
            (i_seconds_right <= 4'd9) &&
            (i_minutes_left <= 3'd5) &&
            (i_seconds_left <= 3'd5) &&
            (ld_h <= 6'd23);
  end

  always_comb begin
    adv    = run_en & ~load_en & (ps == PS_MAX);
    s_wrap = adv & (o_seconds == 6'd59);
    m_wrap = s_wrap & (o_minutes == 6'd59);
    h_wrap = m_wrap & (o_hours == 5'd23);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps          <= '0;
      o_hours     <= '0;
      o_minutes   <= '0;
      o_seconds   <= '0;
      o_sec_tick  <= 1'b0;
      o_min_tick  <= 1'b0;
      o_hour_tick <= 1'b0;
      o_day_tick  <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      o_sec_tick  <= 1'b0;
      o_min_tick  <= 1'b0;
      o_hour_tick <= 1'b0;
      o_day_tick  <= 1'b0;
      o_load_err  <= 1'b0;
      if (load_en) begin
        if (ld_ok) begin
          ps        <= '0;
          o_hours   <= ld_h[4:0];
          o_minutes <= ld_m;
          o_seconds <= ld_s;
        end else begin
          o_load_err <= 1'b1;
        end
      end else if (run_en) begin
        ps <= adv ? '0 : ps + 1'b1;
        if (adv) begin
          o_sec_tick  <= 1'b1;
          o_min_tick  <= s_wrap;
          o_hour_tick <= m_wrap;
          o_day_tick  <= h_wrap;
          o_seconds   <= s_wrap ? 6'd0 : o_seconds + 6'd1;
          if (s_wrap)
            o_minutes <= m_wrap ? 6'd0 : o_minutes + 6'd1;
          if (m_wrap)
            o_hours <= h_wrap ? 5'd0 : o_hours + 5'd1;
        end
      end
    end
  end

  always_comb begin
    o_hours_disp = o_hours;
    o_pm         = (o_hours >= 5'd12);
    if (mode_12h) begin
      unique case (1'b1)
        (o_hours == 5'd0): o_hours_disp = 5'd12;
        (o_hours > 5'd12): o_hours_disp = o_hours - 5'd12;
        default:           o_hours_disp = o_hours;
      endcase
    end
  end

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench for timekeeper_core at four clocks per second.
module tb_timekeeper_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en, load_en, mode_12h;
  logic [1:0] hl;
  logic [3:0] hr;
  logic [2:0] ml;
  logic [3:0] mr;
  logic [2:0] sl;
  logic [3:0] sr;
  logic [4:0] o_hours, o_hours_disp;
  logic [5:0] o_minutes, o_seconds;
  logic       o_pm, o_sec_tick, o_min_tick;
  logic       o_hour_tick, o_day_tick, o_load_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timekeeper_core #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst),
    .run_en(run_en), .load_en(load_en), .mode_12h(mode_12h),
    .i_hours_left(hl), .i_hours_right(hr),
    .i_minutes_left(ml), .i_minutes_right(mr),
    .i_seconds_left(sl), .i_seconds_right(sr),
    .o_hours(o_hours), .o_minutes(o_minutes),
    .o_seconds(o_seconds), .o_hours_disp(o_hours_disp),
    .o_pm(o_pm), .o_sec_tick(o_sec_tick),
    .o_min_tick(o_min_tick), .o_hour_tick(o_hour_tick),
    .o_day_tick(o_day_tick), .o_load_err(o_load_err)
  );

  typedef struct {
    string      name;
    logic       le, run, mode;
    logic [1:0] hl;
    logic [3:0] hr;
    logic [2:0] ml;
    logic [3:0] mr;
    logic [2:0] sl;
    logic [3:0] sr;
    int         eh, em, es;
    logic [3:0] etk;
    logic       eerr;
    int         edisp;
    logic       epm;
  } vec_t;

  vec_t vec[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ticks();
    return {o_day_tick, o_hour_tick, o_min_tick, o_sec_tick};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string nm, input int h,
                          input int m, input int s);
    chk({nm, ".h"}, 32'(o_hours), h);
    chk({nm, ".m"}, 32'(o_minutes), m);
    chk({nm, ".s"}, 32'(o_seconds), s);
  endtask

  task automatic set_digits(input logic [1:0] a, input logic [3:0] b,
                            input logic [2:0] c, input logic [3:0] d,
                            input logic [2:0] e, input logic [3:0] f);
    hl = a; hr = b; ml = c; mr = d; sl = e; sr = f;
  endtask

  initial begin
    vec[0]  = '{"ld24", 1,0,0, 2,4,0,0,0,0,  0,0,0,   4'b0000,1, 0,0};
    vec[1]  = '{"ld60m",1,0,0, 1,2,6,0,0,0,  0,0,0,   4'b0000,1, 0,0};
    vec[2]  = '{"ld5A", 1,0,0, 0,9,5,10,0,0, 0,0,0,   4'b0000,1, 0,0};
    vec[3]  = '{"ld13", 1,0,0, 1,3,0,5,0,7,  13,5,7,  4'b0000,0, 13,1};
    vec[4]  = '{"m12a", 0,0,1, 0,0,0,0,0,0,  13,5,7,  4'b0000,0, 1,1};
    vec[5]  = '{"ld00", 1,0,1, 0,0,0,0,0,0,  0,0,0,   4'b0000,0, 12,0};
    vec[6]  = '{"ld12", 1,0,1, 1,2,3,4,5,6,  12,34,56,4'b0000,0, 12,1};
    vec[7]  = '{"ld23", 1,1,0, 2,3,5,9,5,8,  23,59,58,4'b0000,0, 23,1};
    vec[8]  = '{"ps1",  0,1,0, 0,0,0,0,0,0,  23,59,58,4'b0000,0, 23,1};
    vec[9]  = '{"ps2",  0,1,0, 0,0,0,0,0,0,  23,59,58,4'b0000,0, 23,1};
    vec[10] = '{"ps3",  0,1,0, 0,0,0,0,0,0,  23,59,58,4'b0000,0, 23,1};
    vec[11] = '{"adv59",0,1,0, 0,0,0,0,0,0,  23,59,59,4'b0001,0, 23,1};
    vec[12] = '{"q1",   0,1,0, 0,0,0,0,0,0,  23,59,59,4'b0000,0, 23,1};
    vec[13] = '{"q2",   0,1,0, 0,0,0,0,0,0,  23,59,59,4'b0000,0, 23,1};
    vec[14] = '{"q3",   0,1,0, 0,0,0,0,0,0,  23,59,59,4'b0000,0, 23,1};
    vec[15] = '{"day",  0,1,0, 0,0,0,0,0,0,  0,0,0,   4'b1111,0, 0,0};
    vec[16] = '{"ld05", 1,0,1, 0,5,0,0,0,0,  5,0,0,   4'b0000,0, 5,0};
    vec[17] = '{"ld60s",1,0,1, 0,0,0,0,6,0,  5,0,0,   4'b0000,1, 5,0};
    vec[18] = '{"ldh10",1,0,0, 0,10,0,0,0,0, 5,0,0,   4'b0000,1, 5,0};

    rst = 1'b1; run_en = 0; load_en = 0; mode_12h = 0;
    set_digits(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk_time("rst", 0, 0, 0);
    chk("rst.tk", 32'(ticks()), 0);
    chk("rst.err", 32'(o_load_err), 0);
    chk("rst.disp24", 32'(o_hours_disp), 0);
    chk("rst.pm", 32'(o_pm), 0);
    mode_12h = 1;
    #1;
    chk("rst.disp12", 32'(o_hours_disp), 12);
    chk("rst.pm12", 32'(o_pm), 0);

    for (int i = 0; i < 19; i++) begin
      load_en = vec[i].le; run_en = vec[i].run;
      mode_12h = vec[i].mode;
      set_digits(vec[i].hl, vec[i].hr, vec[i].ml,
                 vec[i].mr, vec[i].sl, vec[i].sr);
      step();
      chk_time(vec[i].name, vec[i].eh, vec[i].em, vec[i].es);
      chk({vec[i].name, ".tk"}, 32'(ticks()), 32'(vec[i].etk));
      chk({vec[i].name, ".err"}, 32'(o_load_err), 32'(vec[i].eerr));
      chk({vec[i].name, ".disp"}, 32'(o_hours_disp), vec[i].edisp);
      chk({vec[i].name, ".pm"}, 32'(o_pm), 32'(vec[i].epm));
    end

    // prescaler cadence from a fresh load, then a 2-cycle pause
    mode_12h = 0;
    set_digits(0, 0, 0, 0, 0, 0);
    load_en = 1; run_en = 0;
    step();
    load_en = 0; run_en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("cad.tk", 32'(o_sec_tick), (i % 4 == 3) ? 1 : 0);
      chk("cad.s", 32'(o_seconds), (i + 1) / 4);
    end
    step(); step();
    run_en = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("pause.tk", 32'(o_sec_tick), 0);
      chk("pause.s", 32'(o_seconds), 2);
    end
    run_en = 1;
    step();
    chk("resume1.tk", 32'(o_sec_tick), 0);
    step();
    chk("resume2.tk", 32'(o_sec_tick), 1);
    chk("resume2.s", 32'(o_seconds), 3);

    // load held with run_en high freezes time
    set_digits(0, 7, 0, 8, 0, 9);
    load_en = 1; run_en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_time("hold", 7, 8, 9);
      chk("hold.tk", 32'(ticks()), 0);
    end
    load_en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel.tk", 32'(o_sec_tick), (i == 3) ? 1 : 0);
      chk("rel.s", 32'(o_seconds), (i == 3) ? 10 : 9);
    end

    // async reset mid-count at prescaler 2
    set_digits(1, 1, 5, 9, 5, 9);
    load_en = 1; run_en = 0;
    step();
    load_en = 0; run_en = 1;
    step(); step();
    chk_time("pre_rst", 11, 59, 59);
    rst = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst.tk", 32'(ticks()), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst.tk", 32'(ticks()), (i == 3) ? 1 : 0);
      chk("post_rst.s", 32'(o_seconds), (i == 3) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
